sand_update_ctrl: RTL and testbench

Frame-update sequencer for the falling-sand grid. On each `start_i` it scans the cell memory once, bottom-up, and applies the gravity rule to every grain:
- move down if the cell below is empty;
- otherwise move diagonally down (left or right, preference alternating per frame).

It owns the single-port cell RAM's update port. It competes with other masters (e.g. display readout) through a req/grant handshake.

---
 rtl/sand_pkg.sv | 31 +++
 rtl/sand_scan_counter.sv | 85 ++++++++
 rtl/sand_update_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sand_update_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
// -----------------------------------------------------------------------------
// sand_pkg
// Shared types and constants for the falling-sand frame-update sequencer.
//   sand_ctrl_state_t : states of the update FSM in sand_update_ctrl
//   sand_nbr_sel_t    : which landing candidate is being examined
//   CELL_EMPTY        : cell word value that marks an empty cell
// -----------------------------------------------------------------------------
package sand_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_CUR,
    CHK_CUR,
    RD_NBR,
    CHK_NBR,
    WR_DST,
    WR_SRC,
    DONE
  } sand_ctrl_state_t;

  // Landing candidates in the order they are tried. DIAG1/DIAG2 map to
  // left/right depending on the per-frame parity bit.
  typedef enum logic [1:0] {
    BELOW,
    DIAG1,
    DIAG2
  } sand_nbr_sel_t;

  localparam int unsigned CELL_EMPTY = 0;

endpackage : sand_pkg

// File: rtl/sand_scan_counter.sv
// -----------------------------------------------------------------------------
// sand_scan_counter
// Cell position tracker for the bottom-up grid scan. Keeps x, y and the linear
// cell address (y*GRID_W + x) in step so the address never needs a multiply.
//
// Ports
//   clk_i      in   clock
//   rst_i      in   asynchronous active-high reset
//   load_i     in   jump to the first scanned cell (x=0, y=GRID_H-2)
//   adv_i      in   step to the next cell in scan order
//   x_o        out  current column
//   y_o        out  current row
//   cur_addr_o out  linear address of the current cell
//   last_o     out  current cell is the final one (x=GRID_W-1, y=0)
// -----------------------------------------------------------------------------
module sand_scan_counter #(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 48,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_i,
  input  logic                        adv_i,
  output logic [$clog2(GRID_W)-1:0]   x_o,
  output logic [$clog2(GRID_H)-1:0]   y_o,
  output logic [ADDR_WIDTH-1:0]       cur_addr_o,
  output logic                        last_o
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  localparam logic [XW-1:0]         X_MAX      = XW'(GRID_W - 1);
  localparam logic [XW-1:0]         X_ONE      = XW'(1);
  localparam logic [YW-1:0]         Y_START    = YW'(GRID_H - 2);
  localparam logic [YW-1:0]         Y_ONE      = YW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_START = ADDR_WIDTH'((GRID_H - 2) * GRID_W);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  // Going from the end of row y to the start of row y-1 moves back one
  // full row plus the GRID_W-1 cells already walked in this row.
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK   = ADDR_WIDTH'(2 * GRID_W - 1);

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (load_i) begin
      x_d    = '0;
      y_d    = Y_START;
      addr_d = ADDR_START;
    end else if (adv_i) begin
      if (x_q == X_MAX) begin
        x_d    = '0;
        y_d    = y_q - Y_ONE;
        addr_d = addr_q - ROW_BACK;
      end else begin
        x_d    = x_q + X_ONE;
        addr_d = addr_q + ADDR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign cur_addr_o = addr_q;
  assign last_o     = (x_q == X_MAX) && (y_q == '0);

endmodule : sand_scan_counter

// File: rtl/sand_update_ctrl.sv
// -----------------------------------------------------------------------------
// sand_update_ctrl
// Frame-update sequencer for the falling-sand grid. Each start_i triggers one
// bottom-up scan of the cell RAM; every grain moves one row down if it can,
// straight down first, then diagonally (diagonal preference alternates each
// frame). Because landing cells are always in rows already scanned, a grain
// moves at most one row per frame.
//
// Ports
//   clk_i          in   clock
//   rst_i          in   asynchronous active-high reset
//   start_i        in   frame request, honoured only while idle
//   busy_o         out  scan in progress
//   done_o         out  one-cycle pulse after the scan finishes
//   mem_req_o      out  RAM access request
//   mem_grant_i    in   request accepted this cycle
//   mem_we_o       out  1 = write, 0 = read
//   mem_addr_o     out  cell address y*GRID_W + x
//   mem_wr_data_o  out  write data
//   mem_rd_data_i  in   read data, valid the cycle after a granted read
// -----------------------------------------------------------------------------
module sand_update_ctrl
  import sand_pkg::*;
#(
  parameter int GRID_W     = 64,
  parameter int GRID_H     = 48,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  input  logic                  mem_grant_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wr_data_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);

  localparam logic [XW-1:0]         X_MAX      = XW'(GRID_W - 1);
  localparam logic [YW-1:0]         Y_LAST_ROW = YW'(GRID_H - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(GRID_W);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] EMPTY      = DATA_WIDTH'(CELL_EMPTY);

  // ---------------------------------------------------------------------------
  // Scan position
  // ---------------------------------------------------------------------------
  logic                  scan_load;
  logic                  scan_adv;
  logic [XW-1:0]         scan_x;
  logic [YW-1:0]         scan_y;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  scan_last;

  sand_scan_counter #(
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (scan_load),
    .adv_i      (scan_adv),
    .x_o        (scan_x),
    .y_o        (scan_y),
    .cur_addr_o (scan_addr),
    .last_o     (scan_last)
  );

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  sand_ctrl_state_t      state_q, state_d;
  sand_nbr_sel_t         nbr_sel_q, nbr_sel_d;
  logic [ADDR_WIDTH-1:0] nbr_addr_q, nbr_addr_d;
  logic [DATA_WIDTH-1:0] grain_q, grain_d;
  logic                  parity_q, parity_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  step;

  // ---------------------------------------------------------------------------
  // Landing candidates for the grain at the current cell
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] below_addr;
  logic [ADDR_WIDTH-1:0] left_addr;
  logic [ADDR_WIDTH-1:0] right_addr;
  logic                  left_ok;
  logic                  right_ok;
  logic                  diag1_ok;
  logic                  diag2_ok;
  logic [ADDR_WIDTH-1:0] diag1_addr;
  logic [ADDR_WIDTH-1:0] diag2_addr;
  logic                  can_fall;

  assign below_addr = scan_addr + ROW_STEP;
  assign left_addr  = below_addr - ADDR_ONE;
  assign right_addr = below_addr + ADDR_ONE;

  // A diagonal that would leave the grid must be skipped: below-left of x=0
  // is really the last cell of the same row, not a neighbour.
  assign left_ok    = (scan_x != '0);
  assign right_ok   = (scan_x != X_MAX);

  // parity=0 prefers left first, parity=1 prefers right first.
  assign diag1_ok   = parity_q ? right_ok   : left_ok;
  assign diag2_ok   = parity_q ? left_ok    : right_ok;
  assign diag1_addr = parity_q ? right_addr : left_addr;
  assign diag2_addr = parity_q ? left_addr  : right_addr;

  // The bottom row is never loaded into the counter; this keeps a grain from
  // ever addressing below the grid should the scan range be changed.
  assign can_fall   = (scan_y != Y_LAST_ROW);

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    nbr_sel_d  = nbr_sel_q;
    nbr_addr_d = nbr_addr_q;
    grain_d    = grain_q;
    parity_d   = parity_q;
    scan_load  = 1'b0;
    scan_adv   = 1'b0;
    step       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          scan_load = 1'b1;
          state_d   = RD_CUR;
        end
      end

      RD_CUR: begin
        if (mem_grant_i) state_d = CHK_CUR;
      end

      CHK_CUR: begin
        if (mem_rd_data_i == EMPTY || !can_fall) begin
          step = 1'b1;
        end else begin
          grain_d    = mem_rd_data_i;
          nbr_sel_d  = BELOW;
          nbr_addr_d = below_addr;
          state_d    = RD_NBR;
        end
      end

      RD_NBR: begin
        if (mem_grant_i) state_d = CHK_NBR;
      end

      CHK_NBR: begin
        if (mem_rd_data_i == EMPTY) begin
          state_d = WR_DST;
        end else begin
          // Occupied: fall through to the next candidate still on the grid.
          case (nbr_sel_q)
            BELOW: begin
              if (diag1_ok) begin
                nbr_sel_d  = DIAG1;
                nbr_addr_d = diag1_addr;
                state_d    = RD_NBR;
              end else if (diag2_ok) begin
                nbr_sel_d  = DIAG2;
                nbr_addr_d = diag2_addr;
                state_d    = RD_NBR;
              end else begin
                step = 1'b1;
              end
            end
            DIAG1: begin
              if (diag2_ok) begin
                nbr_sel_d  = DIAG2;
                nbr_addr_d = diag2_addr;
                state_d    = RD_NBR;
              end else begin
                step = 1'b1;
              end
            end
            default: step = 1'b1;
          endcase
        end
      end

      WR_DST: begin
        if (mem_grant_i) state_d = WR_SRC;
      end

      WR_SRC: begin
        if (mem_grant_i) step = 1'b1;
      end

      DONE: begin
        parity_d = ~parity_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Move on to the next cell, or finish after the last one.
    if (step) begin
      if (scan_last) begin
        state_d = DONE;
      end else begin
        scan_adv = 1'b1;
        state_d  = RD_CUR;
      end
    end

    // Outputs are decoded from the next state and registered, so they change
    // only on the clock edge and hold steady while a request waits for grant.
    busy_d  = !(state_d inside {IDLE, DONE});
    done_d  = (state_d == DONE);
    req_d   = (state_d inside {RD_CUR, RD_NBR, WR_DST, WR_SRC});
    we_d    = (state_d inside {WR_DST, WR_SRC});
    wdata_d = (state_d == WR_DST) ? grain_d : EMPTY;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      nbr_sel_q  <= BELOW;
      nbr_addr_q <= '0;
      grain_q    <= '0;
      parity_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      nbr_sel_q  <= nbr_sel_d;
      nbr_addr_q <= nbr_addr_d;
      grain_q    <= grain_d;
      parity_q   <= parity_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_wr_data_o = wdata_q;

  // Both address sources are flops; the select comes straight from the state
  // register, so the address is stable for as long as the state is.
  assign mem_addr_o = (state_q == RD_NBR || state_q == WR_DST) ? nbr_addr_q : scan_addr;

endmodule : sand_update_ctrl

// File: tb/tb_sand_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sand_update_ctrl
// Self-checking bench for sand_update_ctrl on a 4x4 grid with a 1-cycle RAM
// model. Expected RAM writes and frame completions are queued when a frame is
// launched; a monitor pops and compares each write and done pulse as the DUT
// presents them. Inputs are driven on the falling edge; the monitor samples
// 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_sand_update_ctrl;

  localparam int GW = 4;
  localparam int GH = 4;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NCELL = GW * GH;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy_o;
  logic          done_o;
  logic          mem_req_o;
  logic          grant;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wr_data_o;
  logic [DW-1:0] rd_data;

  sand_update_ctrl #(
    .GRID_W     (GW),
    .GRID_H     (GH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mem_req_o     (mem_req_o),
    .mem_grant_i   (grant),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_rd_data_i (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // RAM model: 1-cycle read latency; whole-image preload via img/load_img
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [NCELL];
  logic [DW-1:0] img [NCELL];
  logic          load_img;
  int            acc11;   // accesses to address 11 since the last preload

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= img[i];
      acc11 <= 0;
    end else if (mem_req_o && grant) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wr_data_o;
      else          rd_data         <= mem[mem_addr_o];
      if (mem_addr_o == AW'(11)) acc11 <= acc11 + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            is_done;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            busy;
  } exp_t;

  exp_t exp_q[$];
  int   busy_cnt = 0;

  task automatic exp_wr(input int a, input int d);
    exp_q.push_back('{is_done: 1'b0, addr: AW'(a), data: DW'(d), busy: 0});
  endtask

  task automatic exp_done(input int busy_cycles);
    exp_q.push_back('{is_done: 1'b1, addr: '0, data: '0, busy: busy_cycles});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (busy_o) busy_cnt++;
      else if (!done_o) busy_cnt = 0;

      if (mem_req_o && grant && mem_we_o) begin
        check("sb_write_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_write_kind", 32'(e.is_done), 0);
          check("sb_write_addr", 32'(mem_addr_o), 32'(e.addr));
          check("sb_write_data", 32'(mem_wr_data_o), 32'(e.data));
        end
      end

      if (done_o) begin
        check("sb_done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_done_kind", 32'(e.is_done), 1);
          check("sb_done_busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_img();
    for (int i = 0; i < NCELL; i++) img[i] = '0;
  endtask

  task automatic commit_img();
    @(negedge clk);
    load_img = 1'b1;
    @(negedge clk);
    load_img = 1'b0;
  endtask

  task automatic check_mem(input string name, input int a, input int v);
    check(name, 32'(mem[a]), 32'(v));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Launch one frame and wait (bounded) for done_o. Optionally stall the first
  // grain write for 5 cycles, or poke start_i again mid-scan.
  task automatic run_frame(input bit do_stall, input int poke_at);
    bit            seen;
    bit            stalled;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    seen    = 1'b0;
    stalled = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      start = (n == poke_at);
      if (do_stall && !stalled && grant && mem_req_o && mem_we_o && mem_wr_data_o != '0) begin
        stalled  = 1'b1;
        grant    = 1'b0;
        cap_addr = mem_addr_o;
        cap_data = mem_wr_data_o;
        check("stall_at_dst_addr", 32'(cap_addr), 5);
        repeat (5) begin
          @(negedge clk);
          check("stall_req_held",  32'(mem_req_o), 1);
          check("stall_we_held",   32'(mem_we_o), 1);
          check("stall_addr_held", 32'(mem_addr_o), 32'(cap_addr));
          check("stall_data_held", 32'(mem_wr_data_o), 32'(cap_data));
        end
        grant = 1'b1;
      end
      if (done_o) seen = 1'b1;
    end
    start = 1'b0;
    check("frame_done_seen", 32'(seen), 1);
    if (do_stall) check("stall_happened", 32'(stalled), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(busy_o), 0);
    check({tag, "_done"},  32'(done_o), 0);
    check({tag, "_req"},   32'(mem_req_o), 0);
    check({tag, "_we"},    32'(mem_we_o), 0);
    check({tag, "_addr"},  32'(mem_addr_o), 0);
    check({tag, "_wdata"}, 32'(mem_wr_data_o), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    rst      = 1'b0;
    start    = 1'b0;
    grant    = 1'b1;
    load_img = 1'b0;
    clear_img();

    // Asynchronous reset takes effect before any clock edge.
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1. Empty grid: 12 cells x 2 cycles, no writes.
    commit_img();
    exp_done(24);
    run_frame(1'b0, -1);

    // 2. Falling grain from addr 1 to addr 13 over three frames.
    clear_img();
    img[1] = 8'h05;
    commit_img();
    exp_wr(5, 8'h05);  exp_wr(1, 0);  exp_done(28);
    run_frame(1'b0, -1);
    check_mem("fall_f1_a5", 5, 8'h05);
    check_mem("fall_f1_a1", 1, 0);
    exp_wr(9, 8'h05);  exp_wr(5, 0);  exp_done(28);
    run_frame(1'b0, -1);
    exp_wr(13, 8'h05); exp_wr(9, 0);  exp_done(28);
    run_frame(1'b0, -1);
    check_mem("fall_f3_a13", 13, 8'h05);
    check_mem("fall_f3_a9", 9, 0);
    exp_done(24);
    run_frame(1'b0, -1);
    check_mem("fall_f4_a13", 13, 8'h05);

    // 3. Diagonal choice: parity 0 goes left, parity 1 goes right.
    pulse_reset();
    clear_img();
    img[9]  = 8'h07;
    img[13] = 8'h03;
    commit_img();
    exp_wr(12, 8'h07); exp_wr(9, 0); exp_done(30);
    run_frame(1'b0, -1);
    check_mem("diag_p0_a12", 12, 8'h07);
    check_mem("diag_p0_a13", 13, 8'h03);
    commit_img();
    exp_wr(14, 8'h07); exp_wr(9, 0); exp_done(30);
    run_frame(1'b0, -1);
    check_mem("diag_p1_a14", 14, 8'h07);
    check_mem("diag_p1_a12", 12, 0);

    // 4. Left edge: below-left of x=0 is skipped under either parity; addr 11
    //    is touched only as its own current-cell read.
    clear_img();
    img[8]  = 8'h09;
    img[12] = 8'h02;
    commit_img();
    exp_wr(13, 8'h09); exp_wr(8, 0); exp_done(30);
    run_frame(1'b0, -1);
    check_mem("edge_p0_a13", 13, 8'h09);
    check("edge_p0_acc11", 32'(acc11), 1);
    commit_img();
    exp_wr(13, 8'h09); exp_wr(8, 0); exp_done(30);
    run_frame(1'b0, -1);
    check_mem("edge_p1_a13", 13, 8'h09);
    check("edge_p1_acc11", 32'(acc11), 1);

    // 5. Grant stall of 5 cycles on the destination write.
    clear_img();
    img[1] = 8'h05;
    commit_img();
    exp_wr(5, 8'h05); exp_wr(1, 0); exp_done(33);
    run_frame(1'b1, -1);
    check_mem("stall_a5", 5, 8'h05);
    check_mem("stall_a1", 1, 0);

    // 6a. start_i mid-scan is ignored: exactly one done pulse.
    clear_img();
    commit_img();
    exp_done(24);
    run_frame(1'b0, 10);
    repeat (30) @(negedge clk);

    // 6b. Reset mid-scan clears outputs at once; the next frame is complete.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midscan_busy_before_reset", 32'(busy_o), 1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midscan_reset");
    @(negedge clk);
    rst = 1'b0;
    exp_done(24);
    run_frame(1'b0, -1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sand_update_ctrl
